// File: rtl/mux_pkg.sv
// Shared helpers for the parametrised select muxes: constant clog2 and popcount.
package mux_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        // A single-slot mux still needs a 1-bit index port.
        return (r == 0) ? 1 : r;
    endfunction

    // Select vectors wider than 64 lines are not supported.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            cnt = cnt + 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// N-input priority encoder: bit 0 wins; idx = N when no line is set.
module prio_enc_n
    import mux_pkg::*;
#(
    parameter int unsigned N = 5,
    localparam int unsigned IW = clog2(N + 1)
) (
    input  logic [N-1:0]  sel,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          multi
);

    always_comb begin
        idx   = IW'(N);
        any   = 1'b0;
        multi = popcount(64'(sel)) > 1;
        for (int k = N - 1; k >= 0; k--) begin
            if (sel[k]) begin
                idx = IW'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_prio_pipe.sv
// Priority-select mux with a one-deep valid/ready output register,
// flush, selected-slot reporting and a saturating multi-hot conflict counter.
module mux_prio_pipe
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSEL  = 5,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned IDX_W = clog2(NSEL + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [(NSEL+1)*WIDTH-1:0] in_data,
    input  logic [NSEL-1:0]           sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      multi_hot,
    output logic [CNT_W-1:0]          conflict_cnt
);

    logic [IDX_W-1:0] idx;
    logic             any;
    logic             multi;
    logic [WIDTH-1:0] slot_sel;
    logic             accept;

    prio_enc_n #(.N(NSEL)) u_enc (
        .sel   (sel),
        .idx   (idx),
        .any   (any),
        .multi (multi)
    );

    // Slot NSEL is the default when no select line is active.
    always_comb begin
        slot_sel = in_data[NSEL*WIDTH +: WIDTH];
        for (int unsigned k = 0; k < NSEL; k++) begin
            if (any && idx == IDX_W'(k)) begin
                slot_sel = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Output stage: flush beats drain, accept beats capture/refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            multi_hot <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= slot_sel;
            out_idx   <= idx;
            multi_hot <= multi;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (accept && multi && conflict_cnt != {CNT_W{1'b1}}) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/mux_prio_pipe.md
# mux_prio_pipe

Parametrised N-way priority multiplexer with a one-deep registered output stage and valid/ready handshake; the generalised successor to the fixed-width, fixed-arity select muxes in the datapath. It sits on pipeline boundaries such as the EX-stage forwarding select and the PC-source select, so that operand selection and the stage register live in one block. Over the plain muxes it adds stall/back-pressure, flush, selected-slot reporting and a saturating count of multi-hot select conflicts.

## Interface
- WIDTH, 32, data width of every slot.
- NSEL, 5, number of select lines. There are NSEL+1 data slots; slot NSEL is the default.
- CNT_W, 8, width of the conflict counter.
- IDX_W, derived as clog2(NSEL+1), width of out_idx. It is not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  (NSEL+1)*WIDTH  flattened slots; slot k is at [k*WIDTH +: WIDTH].
- sel  in  NSEL  select lines; sel[0] has highest priority.
- in_valid  in  1  the input beat is present.
- in_ready  out  1  the block can accept a beat this cycle.
- flush  in  1  discard the held beat and block capture.
- out_data  out  WIDTH  registered selected data.
- out_idx  out  IDX_W  registered index of the selected slot (NSEL = default).
- out_valid  out  1  out_data holds a beat.
- out_ready  in  1  the consumer takes the beat.
- multi_hot  out  1  registered flag: the held beat had popcount(sel) > 1.
- conflict_cnt  out  CNT_W  saturating count of accepted multi-hot beats.

## Operation
- Selection is combinational. idx = lowest k with sel[k]=1. If sel is all zero, idx = NSEL (default slot).
- Accept condition is in_valid && in_ready. in_ready = !flush && (!out_valid || out_ready).
- On accept, the next edge captures:
  - out_data = slot[idx]
  - out_idx = idx
  - multi_hot = (popcount(sel) > 1)
  - out_valid = 1
- Drain without refill: if out_valid && out_ready and there is no accept, the next edge sets out_valid = 0. out_data, out_idx and multi_hot hold their stale values.
- Stall: if out_valid && !out_ready, all output registers hold and in_ready = 0.
- Flush: out_valid = 0 at the next edge regardless of other inputs. A beat presented in the flush cycle is not accepted. conflict_cnt is unaffected.
- conflict_cnt increments by 1 on each accepted multi-hot beat. It saturates at 2^CNT_W-1 and never wraps. Only rst clears it.
- Reset: when rst is asserted, all registered outputs clear immediately and asynchronously to 0. This applies mid-stall and mid-transfer alike, and the beat is lost.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 beat per cycle while out_ready = 1.
- in_ready is combinational from out_valid, out_ready and flush, with no dependence on in_valid.
- out_data, out_idx, multi_hot and out_valid are all registered, with no combinational path from any input.
- Simultaneous accept and drain in the same cycle counts as a refill, and out_valid stays 1.
- Simultaneous flush and out_ready: flush wins, out_valid goes to 0 and there is no capture.
- Reset values: out_data = 0, out_idx = 0, out_valid = 0, multi_hot = 0, conflict_cnt = 0. in_ready = 1 after reset, provided flush = 0.

## Structure
- The shared package mux_pkg holds the clog2 constant function and a popcount function. All parametrised muxes reuse it.
- One combinational sub-module, prio_enc_n (parameter N), takes sel[N-1:0] and produces idx, any and multi.
- The top level contains the slot-select, the handshake register and the counter.

## Test plan
- Basic selection with WIDTH=32, NSEL=5, slots = 0x10..0x15, out_ready=1:
  - sel=5'b00100 gives out_data=0x12, out_idx=2 one cycle later.
  - sel=0 gives 0x15, idx=5.
- Priority with sel=5'b10110 gives out_data=0x11, idx=1 and multi_hot=1. conflict_cnt goes 0 to 1.
- Back-pressure: hold out_ready=0 with out_valid=1 for 3 cycles. in_ready=0 and the outputs are stable throughout. Raising out_ready with a new beat gives a back-to-back refill with no bubble.
- Flush:
  - flush while out_valid=1 and in_valid=1 gives out_valid=0 next cycle, no capture, and conflict_cnt unchanged.
  - A beat after flush is captured normally.
- Saturation with CNT_W=2: five accepted multi-hot beats leave conflict_cnt = 3.
- Asynchronous reset asserted mid-stall, between clock edges, clears out_valid and conflict_cnt immediately. in_ready=1 after release.
